sfp_port_ctrl: RTL and testbench
================================

Name: sfp_port_ctrl

Overview:
Parametrised multi-port SFP cage controller, successor to the single hard-wired ETH1 cage handling at top level. Per port it synchronises and debounces TX_FAULT/RX_LOS, drives TX_DISABLE through a power-up/fault-retry state machine, qualifies link-up with PCS block lock, and drives a status LED. It sits between the board SFP pins and the per-port 10G Ethernet MAC/PCS instances in the top level.

Parameters:
NUM_PORTS, 4, number of SFP cages (1..8)
DEBOUNCE_CYCLES, 1024, consecutive stable synced samples required to change a debounced input (>=2)
INIT_CYCLES, 50000, TX_DISABLE-low settle time before TX_FAULT is trusted (t_init)
RETRY_CYCLES, 156250, TX_DISABLE-high hold time per fault retry
MAX_RETRIES, 3, fault retries before permanent lockout (>=1)
BLINK_CYCLES, 7812500, LED half-period for blink states

Ports:
sys_clk  in  1  single clock, all logic
sys_rst_n  in  1  synchronous active-low reset
port_enable  in  NUM_PORTS  per-port enable, level
sfp_tx_fault  in  NUM_PORTS  TX_FAULT pins, asynchronous
sfp_rx_los  in  NUM_PORTS  RX_LOS pins, asynchronous
pcs_block_lock  in  NUM_PORTS  PCS block lock, sys_clk domain
fault_clear  in  NUM_PORTS  one-cycle pulse, releases FAULT_LOCKED
sfp_tx_disable  out  NUM_PORTS  TX_DISABLE pins, registered
link_up  out  NUM_PORTS  port in LINK_UP, registered
fault_locked  out  NUM_PORTS  port in FAULT_LOCKED, registered
port_state  out  3*NUM_PORTS  state encoding, port i at [3i+2:3i]
led  out  NUM_PORTS  status LED, active-high

Behaviour:
- Reset (sys_rst_n=0 at edge): all ports DISABLED; sfp_tx_disable=all 1; link_up=0; fault_locked=0; led=0; port_state=0; debounced tx_fault=0, rx_los=1; retry counters, timers, blink counter=0; synchroniser flops tx_fault=0, rx_los=1. Reset mid-operation: same, takes effect on that edge.
- Sync: 2-flop synchroniser per async input.
- Debounce: counter increments while synced != debounced, clears when equal; debounced value flips on the edge where counter would reach DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES cycles after first differing synced sample. A glitch shorter than DEBOUNCE_CYCLES never propagates.
- States: DISABLED=0, STARTUP=1, WAIT_SIGNAL=2, LINK_UP=3, FAULT_BACKOFF=4, FAULT_LOCKED=5.
- Priority: port_enable=0 -> DISABLED next edge from any state, retry count cleared; overrides fault_clear and all others.
- DISABLED: tx_disable=1; port_enable=1 -> STARTUP, timer=INIT_CYCLES-1.
- STARTUP: tx_disable=0; timer counts down; at 0: debounced fault -> FAULT_BACKOFF else WAIT_SIGNAL. TX_FAULT ignored before expiry.
- WAIT_SIGNAL: debounced fault -> FAULT_BACKOFF (priority); else !rx_los && pcs_block_lock -> LINK_UP.
- LINK_UP: retry count cleared on entry; fault -> FAULT_BACKOFF (priority); rx_los || !pcs_block_lock -> WAIT_SIGNAL.
- FAULT_BACKOFF: entry increments retry count, timer=RETRY_CYCLES-1, tx_disable=1; at timer 0: retry count==MAX_RETRIES -> FAULT_LOCKED else STARTUP.
- FAULT_LOCKED: tx_disable=1; fault_clear=1 -> DISABLED, retry count=0 (re-enters STARTUP next cycle if enabled). fault_clear in other states ignored.
- Outputs registered: state-derived outputs valid the edge the state register updates (no extra cycle).
- LED: LINK_UP=1; FAULT_BACKOFF and FAULT_LOCKED = shared blink phase (toggles every BLINK_CYCLES, free-running, common to all ports); else 0.
- Ports fully independent; counters width $clog2(param+1).

Optional Feature:
SFP_LINK_DOWN_CNT_EN: adds output link_down_cnt [16*NUM_PORTS], per-port 16-bit counter incremented on each LINK_UP->any transition, saturates at 0xFFFF, cleared by reset only. Without macro: port absent, no counter logic.

Test Plan:
Sim params DEBOUNCE_CYCLES=4, INIT_CYCLES=8, RETRY_CYCLES=16, MAX_RETRIES=2, BLINK_CYCLES=4, NUM_PORTS=2.
Reset, enable port0, rx_los=0, block_lock=1 -> tx_disable0 falls 1 cycle after enable, link_up0=1 after STARTUP expiry+1, port_state0=3; port1 stays 0, tx_disable1=1.
In LINK_UP, 3-cycle rx_los pulse -> no change; 6-cycle pulse -> link_up0=0 exactly 2+4+1 cycles after pin edge, returns to 3 after LOS deasserts and debounces.
tx_fault held 1 -> STARTUP/FAULT_BACKOFF twice, then port_state=5, fault_locked=1, tx_disable=1, led toggling every 4 cycles; fault_clear pulse with fault removed -> DISABLED then STARTUP -> LINK_UP.
port_enable dropped during FAULT_BACKOFF -> port_state=0 next edge, tx_disable=1, retry count 0 (re-enable then fault needs 2 more retries to lock).
sys_rst_n=0 for one cycle while in LINK_UP -> all outputs to reset values on that edge; with SFP_LINK_DOWN_CNT_EN, 3 link drops -> link_down_cnt0=3.

Source files
------------

// File: rtl/sfp_port_ctrl.sv
// Multi-port SFP cage controller: input sync/debounce, TX_DISABLE power-up/fault-retry FSM,
// link qualification with PCS block lock and status LED. Optional macro: SFP_LINK_DOWN_CNT_EN.
module sfp_port_ctrl #(
    parameter int NUM_PORTS       = 4,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int INIT_CYCLES     = 50000,
    parameter int RETRY_CYCLES    = 156250,
    parameter int MAX_RETRIES     = 3,
    parameter int BLINK_CYCLES    = 7812500
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [NUM_PORTS-1:0]   port_enable,
    input  logic [NUM_PORTS-1:0]   sfp_tx_fault,
    input  logic [NUM_PORTS-1:0]   sfp_rx_los,
    input  logic [NUM_PORTS-1:0]   pcs_block_lock,
    input  logic [NUM_PORTS-1:0]   fault_clear,
    output logic [NUM_PORTS-1:0]   sfp_tx_disable,
    output logic [NUM_PORTS-1:0]   link_up,
    output logic [NUM_PORTS-1:0]   fault_locked,
    output logic [3*NUM_PORTS-1:0] port_state,
`ifdef SFP_LINK_DOWN_CNT_EN
    output logic [NUM_PORTS-1:0]    led,
    output logic [16*NUM_PORTS-1:0] link_down_cnt
`else
    output logic [NUM_PORTS-1:0]   led
`endif
);

    typedef enum logic [2:0] {
        ST_DISABLED      = 3'd0,
        ST_STARTUP       = 3'd1,
        ST_WAIT_SIGNAL   = 3'd2,
        ST_LINK_UP       = 3'd3,
        ST_FAULT_BACKOFF = 3'd4,
        ST_FAULT_LOCKED  = 3'd5
    } state_e;

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (INIT_CYCLES > RETRY_CYCLES) ? INIT_CYCLES : RETRY_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MAX_RETRIES + 1);
    localparam int BW   = $clog2(BLINK_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] INIT_LAST  = TW'(INIT_CYCLES - 1);
    localparam logic [TW-1:0] RETRY_LAST = TW'(RETRY_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    // Free-running blink phase shared by every port so fault LEDs flash in unison.
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic          tf_meta_q, tf_sync_q, los_meta_q, los_sync_q;
        logic          tf_deb_q, tf_deb_d, los_deb_q, los_deb_d;
        logic [DW-1:0] tf_cnt_q, tf_cnt_d, los_cnt_q, los_cnt_d;
        state_e        state_q, state_d;
        logic [TW-1:0] timer_q, timer_d;
        logic [RW-1:0] retry_q, retry_d;
        logic          go_backoff;
        logic          tx_dis_q, tx_dis_d, link_q, link_d, locked_q, locked_d, led_q, led_d;

        // Debounced value flips only after DEBOUNCE_CYCLES consecutive differing samples.
        always_comb begin
            tf_cnt_d  = '0;
            tf_deb_d  = tf_deb_q;
            los_cnt_d = '0;
            los_deb_d = los_deb_q;
            if (tf_sync_q != tf_deb_q) begin
                if (tf_cnt_q == DB_LAST) tf_deb_d = tf_sync_q;
                else                     tf_cnt_d = tf_cnt_q + 1'b1;
            end
            if (los_sync_q != los_deb_q) begin
                if (los_cnt_q == DB_LAST) los_deb_d = los_sync_q;
                else                      los_cnt_d = los_cnt_q + 1'b1;
            end
        end

        always_comb begin
            state_d    = state_q;
            timer_d    = timer_q;
            retry_d    = retry_q;
            go_backoff = 1'b0;
            if (!port_enable[i]) begin
                state_d = ST_DISABLED;
                retry_d = '0;
            end else begin
                case (state_q)
                    ST_DISABLED: begin
                        state_d = ST_STARTUP;
                        timer_d = INIT_LAST;
                    end
                    ST_STARTUP: begin
                        if (timer_q != '0) timer_d = timer_q - 1'b1;
                        else if (tf_deb_q) go_backoff = 1'b1;
                        else               state_d = ST_WAIT_SIGNAL;
                    end
                    ST_WAIT_SIGNAL: begin
                        if (tf_deb_q) begin
                            go_backoff = 1'b1;
                        end else if (!los_deb_q && pcs_block_lock[i]) begin
                            state_d = ST_LINK_UP;
                            retry_d = '0;
                        end
                    end
                    ST_LINK_UP: begin
                        if (tf_deb_q)                            go_backoff = 1'b1;
                        else if (los_deb_q || !pcs_block_lock[i]) state_d = ST_WAIT_SIGNAL;
                    end
                    ST_FAULT_BACKOFF: begin
                        if (timer_q != '0) begin
                            timer_d = timer_q - 1'b1;
                        end else if (retry_q == RETRY_MAX) begin
                            state_d = ST_FAULT_LOCKED;
                        end else begin
                            state_d = ST_STARTUP;
                            timer_d = INIT_LAST;
                        end
                    end
                    ST_FAULT_LOCKED: begin
                        if (fault_clear[i]) begin
                            state_d = ST_DISABLED;
                            retry_d = '0;
                        end
                    end
                    default: state_d = ST_DISABLED;
                endcase
            end
            if (go_backoff) begin
                state_d = ST_FAULT_BACKOFF;
                retry_d = retry_q + 1'b1;
                timer_d = RETRY_LAST;
            end
            // Outputs follow the next state so they update on the same edge as the state register.
            tx_dis_d = (state_d == ST_DISABLED) || (state_d == ST_FAULT_BACKOFF) ||
                       (state_d == ST_FAULT_LOCKED);
            link_d   = (state_d == ST_LINK_UP);
            locked_d = (state_d == ST_FAULT_LOCKED);
            led_d    = link_d || (((state_d == ST_FAULT_BACKOFF) || locked_d) && blink_d);
        end

        always_ff @(posedge sys_clk) begin
            if (!sys_rst_n) begin
                tf_meta_q  <= 1'b0;
                tf_sync_q  <= 1'b0;
                los_meta_q <= 1'b1;
                los_sync_q <= 1'b1;
                tf_deb_q   <= 1'b0;
                los_deb_q  <= 1'b1;
                tf_cnt_q   <= '0;
                los_cnt_q  <= '0;
                state_q    <= ST_DISABLED;
                timer_q    <= '0;
                retry_q    <= '0;
                tx_dis_q   <= 1'b1;
                link_q     <= 1'b0;
                locked_q   <= 1'b0;
                led_q      <= 1'b0;
            end else begin
                tf_meta_q  <= sfp_tx_fault[i];
                tf_sync_q  <= tf_meta_q;
                los_meta_q <= sfp_rx_los[i];
                los_sync_q <= los_meta_q;
                tf_deb_q   <= tf_deb_d;
                los_deb_q  <= los_deb_d;
                tf_cnt_q   <= tf_cnt_d;
                los_cnt_q  <= los_cnt_d;
                state_q    <= state_d;
                timer_q    <= timer_d;
                retry_q    <= retry_d;
                tx_dis_q   <= tx_dis_d;
                link_q     <= link_d;
                locked_q   <= locked_d;
                led_q      <= led_d;
            end
        end

        assign sfp_tx_disable[i]     = tx_dis_q;
        assign link_up[i]            = link_q;
        assign fault_locked[i]       = locked_q;
        assign led[i]                = led_q;
        assign port_state[3*i +: 3]  = state_q;

`ifdef SFP_LINK_DOWN_CNT_EN
        logic [15:0] ldc_q;

        always_ff @(posedge sys_clk) begin
            if (!sys_rst_n) begin
                ldc_q <= '0;
            end else if ((state_q == ST_LINK_UP) && (state_d != ST_LINK_UP) &&
                         (ldc_q != 16'hFFFF)) begin
                ldc_q <= ldc_q + 1'b1;
            end
        end

        assign link_down_cnt[16*i +: 16] = ldc_q;
`endif
    end

endmodule

// File: tb/tb_sfp_port_ctrl.sv
// Directed bench for sfp_port_ctrl with small timing parameters; inputs change and outputs
// are sampled on the falling clock edge.
module tb_sfp_port_ctrl;

    localparam int NP = 2;

    logic            sys_clk = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic [NP-1:0]   port_enable = '0;
    logic [NP-1:0]   sfp_tx_fault = '0;
    logic [NP-1:0]   sfp_rx_los = '1;
    logic [NP-1:0]   pcs_block_lock = '0;
    logic [NP-1:0]   fault_clear = '0;
    logic [NP-1:0]   sfp_tx_disable;
    logic [NP-1:0]   link_up;
    logic [NP-1:0]   fault_locked;
    logic [3*NP-1:0] port_state;
    logic [NP-1:0]   led;
`ifdef SFP_LINK_DOWN_CNT_EN
    logic [16*NP-1:0] link_down_cnt;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned edges = 0;
    logic        exp_led;

    sfp_port_ctrl #(
        .NUM_PORTS(NP), .DEBOUNCE_CYCLES(4), .INIT_CYCLES(8),
        .RETRY_CYCLES(16), .MAX_RETRIES(2), .BLINK_CYCLES(4)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .port_enable(port_enable),
        .sfp_tx_fault(sfp_tx_fault), .sfp_rx_los(sfp_rx_los),
        .pcs_block_lock(pcs_block_lock), .fault_clear(fault_clear),
        .sfp_tx_disable(sfp_tx_disable), .link_up(link_up), .fault_locked(fault_locked),
        .port_state(port_state),
`ifdef SFP_LINK_DOWN_CNT_EN
        .led(led), .link_down_cnt(link_down_cnt)
`else
        .led(led)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Edges since reset release; blink phase expected = (edges / 4) % 2.
    always @(posedge sys_clk) begin
        if (!sys_rst_n) edges <= 0;
        else            edges <= edges + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        tick(3);
        n_checks++; if (sfp_tx_disable !== 2'b11) begin n_fail++; $display("FAIL reset_txdis got=%b exp=11", sfp_tx_disable); end
        n_checks++; if (link_up !== 2'b00) begin n_fail++; $display("FAIL reset_link got=%b exp=00", link_up); end
        n_checks++; if (fault_locked !== 2'b00) begin n_fail++; $display("FAIL reset_locked got=%b exp=00", fault_locked); end
        n_checks++; if (led !== 2'b00) begin n_fail++; $display("FAIL reset_led got=%b exp=00", led); end
        n_checks++; if (port_state !== 6'd0) begin n_fail++; $display("FAIL reset_state got=%h exp=0", port_state); end
        sys_rst_n = 1'b1;
        sfp_rx_los = 2'b00;
        pcs_block_lock = 2'b01;
        tick(10);
        n_checks++; if (port_state !== 6'd0 || sfp_tx_disable !== 2'b11) begin n_fail++; $display("FAIL idle_disabled state=%h txdis=%b exp=0/11", port_state, sfp_tx_disable); end
    endtask

    task automatic test_enable_link();
        port_enable[0] = 1'b1;
        tick(1);
        n_checks++; if (sfp_tx_disable !== 2'b10) begin n_fail++; $display("FAIL en_txdis got=%b exp=10", sfp_tx_disable); end
        n_checks++; if (port_state[2:0] !== 3'd1) begin n_fail++; $display("FAIL en_startup got=%0d exp=1", port_state[2:0]); end
        tick(8);
        n_checks++; if (port_state[2:0] !== 3'd2 || link_up[0] !== 1'b0) begin n_fail++; $display("FAIL en_wait state=%0d link=%b exp=2/0", port_state[2:0], link_up[0]); end
        tick(1);
        n_checks++; if (port_state[2:0] !== 3'd3 || link_up !== 2'b01 || led !== 2'b01) begin n_fail++; $display("FAIL en_linkup state=%0d link=%b led=%b exp=3/01/01", port_state[2:0], link_up, led); end
        n_checks++; if (port_state[5:3] !== 3'd0 || sfp_tx_disable[1] !== 1'b1) begin n_fail++; $display("FAIL port1_idle state=%0d txdis=%b exp=0/1", port_state[5:3], sfp_tx_disable[1]); end
    endtask

    task automatic test_los_glitch();
        sfp_rx_los[0] = 1'b1;
        tick(3);
        sfp_rx_los[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            n_checks++; if (link_up[0] !== 1'b1) begin n_fail++; $display("FAIL los_glitch cyc=%0d link=%b exp=1", k, link_up[0]); end
        end
    endtask

    task automatic test_los_pulse();
        sfp_rx_los[0] = 1'b1;
        tick(6);
        n_checks++; if (link_up[0] !== 1'b1 || port_state[2:0] !== 3'd3) begin n_fail++; $display("FAIL los_early link=%b state=%0d exp=1/3", link_up[0], port_state[2:0]); end
        sfp_rx_los[0] = 1'b0;
        tick(1);
        n_checks++; if (link_up[0] !== 1'b0 || port_state[2:0] !== 3'd2 || led[0] !== 1'b0) begin n_fail++; $display("FAIL los_drop link=%b state=%0d led=%b exp=0/2/0", link_up[0], port_state[2:0], led[0]); end
        tick(5);
        n_checks++; if (port_state[2:0] !== 3'd2) begin n_fail++; $display("FAIL los_hold state=%0d exp=2", port_state[2:0]); end
        tick(1);
        n_checks++; if (port_state[2:0] !== 3'd3 || link_up[0] !== 1'b1) begin n_fail++; $display("FAIL los_recover state=%0d link=%b exp=3/1", port_state[2:0], link_up[0]); end
    endtask

    task automatic test_fault_lockout();
        sfp_tx_fault[0] = 1'b1;
        tick(6);
        n_checks++; if (port_state[2:0] !== 3'd3) begin n_fail++; $display("FAIL flt_early state=%0d exp=3", port_state[2:0]); end
        tick(1);
        exp_led = ((edges / 4) % 2) == 1;
        n_checks++; if (port_state[2:0] !== 3'd4 || sfp_tx_disable[0] !== 1'b1 || link_up[0] !== 1'b0) begin n_fail++; $display("FAIL flt_backoff1 state=%0d txdis=%b link=%b exp=4/1/0", port_state[2:0], sfp_tx_disable[0], link_up[0]); end
        n_checks++; if (led[0] !== exp_led) begin n_fail++; $display("FAIL flt_led_backoff got=%b exp=%b", led[0], exp_led); end
        tick(15);
        n_checks++; if (port_state[2:0] !== 3'd4) begin n_fail++; $display("FAIL flt_backoff1_end state=%0d exp=4", port_state[2:0]); end
        tick(1);
        n_checks++; if (port_state[2:0] !== 3'd1 || sfp_tx_disable[0] !== 1'b0) begin n_fail++; $display("FAIL flt_retry state=%0d txdis=%b exp=1/0", port_state[2:0], sfp_tx_disable[0]); end
        tick(7);
        n_checks++; if (port_state[2:0] !== 3'd1) begin n_fail++; $display("FAIL flt_retry_end state=%0d exp=1", port_state[2:0]); end
        tick(1);
        n_checks++; if (port_state[2:0] !== 3'd4) begin n_fail++; $display("FAIL flt_backoff2 state=%0d exp=4", port_state[2:0]); end
        tick(15);
        n_checks++; if (port_state[2:0] !== 3'd4 || fault_locked[0] !== 1'b0) begin n_fail++; $display("FAIL flt_backoff2_end state=%0d locked=%b exp=4/0", port_state[2:0], fault_locked[0]); end
        tick(1);
        n_checks++; if (port_state[2:0] !== 3'd5 || fault_locked[0] !== 1'b1 || sfp_tx_disable[0] !== 1'b1) begin n_fail++; $display("FAIL flt_locked state=%0d locked=%b txdis=%b exp=5/1/1", port_state[2:0], fault_locked[0], sfp_tx_disable[0]); end
        for (int k = 0; k < 12; k++) begin
            tick(1);
            exp_led = ((edges / 4) % 2) == 1;
            n_checks++; if (led !== {1'b0, exp_led}) begin n_fail++; $display("FAIL flt_blink cyc=%0d got=%b exp=0%b", k, led, exp_led); end
        end
    endtask

    task automatic test_fault_clear();
        sfp_tx_fault[0] = 1'b0;
        tick(8);
        n_checks++; if (port_state[2:0] !== 3'd5) begin n_fail++; $display("FAIL clr_still_locked state=%0d exp=5", port_state[2:0]); end
        fault_clear[0] = 1'b1;
        tick(1);
        fault_clear[0] = 1'b0;
        n_checks++; if (port_state[2:0] !== 3'd0 || sfp_tx_disable[0] !== 1'b1 || fault_locked[0] !== 1'b0) begin n_fail++; $display("FAIL clr_disabled state=%0d txdis=%b locked=%b exp=0/1/0", port_state[2:0], sfp_tx_disable[0], fault_locked[0]); end
        tick(1);
        n_checks++; if (port_state[2:0] !== 3'd1 || sfp_tx_disable[0] !== 1'b0) begin n_fail++; $display("FAIL clr_startup state=%0d txdis=%b exp=1/0", port_state[2:0], sfp_tx_disable[0]); end
        tick(9);
        n_checks++; if (port_state[2:0] !== 3'd3 || link_up[0] !== 1'b1) begin n_fail++; $display("FAIL clr_linkup state=%0d link=%b exp=3/1", port_state[2:0], link_up[0]); end
        fault_clear[0] = 1'b1;
        tick(1);
        fault_clear[0] = 1'b0;
        n_checks++; if (port_state[2:0] !== 3'd3) begin n_fail++; $display("FAIL clr_ignored state=%0d exp=3", port_state[2:0]); end
    endtask

    task automatic test_enable_drop();
        sfp_tx_fault[0] = 1'b1;
        tick(7);
        n_checks++; if (port_state[2:0] !== 3'd4) begin n_fail++; $display("FAIL drop_backoff state=%0d exp=4", port_state[2:0]); end
        tick(2);
        port_enable[0] = 1'b0;
        tick(1);
        n_checks++; if (port_state[2:0] !== 3'd0 || sfp_tx_disable[0] !== 1'b1 || led[0] !== 1'b0) begin n_fail++; $display("FAIL drop_disabled state=%0d txdis=%b led=%b exp=0/1/0", port_state[2:0], sfp_tx_disable[0], led[0]); end
        port_enable[0] = 1'b1;
        tick(1);
        n_checks++; if (port_state[2:0] !== 3'd1) begin n_fail++; $display("FAIL drop_restart state=%0d exp=1", port_state[2:0]); end
        tick(8);
        n_checks++; if (port_state[2:0] !== 3'd4) begin n_fail++; $display("FAIL drop_retry1 state=%0d exp=4", port_state[2:0]); end
        tick(16);
        n_checks++; if (port_state[2:0] !== 3'd1) begin n_fail++; $display("FAIL drop_count_cleared state=%0d exp=1", port_state[2:0]); end
        tick(8);
        n_checks++; if (port_state[2:0] !== 3'd4) begin n_fail++; $display("FAIL drop_retry2 state=%0d exp=4", port_state[2:0]); end
        tick(16);
        n_checks++; if (port_state[2:0] !== 3'd5) begin n_fail++; $display("FAIL drop_locked state=%0d exp=5", port_state[2:0]); end
    endtask

    task automatic test_reset_mid();
        sfp_tx_fault[0] = 1'b0;
        tick(8);
        fault_clear[0] = 1'b1;
        tick(1);
        fault_clear[0] = 1'b0;
        tick(10);
        n_checks++; if (port_state[2:0] !== 3'd3) begin n_fail++; $display("FAIL rst_pre_linkup state=%0d exp=3", port_state[2:0]); end
        sys_rst_n = 1'b0;
        tick(1);
        n_checks++; if (sfp_tx_disable !== 2'b11 || link_up !== 2'b00 || fault_locked !== 2'b00) begin n_fail++; $display("FAIL rst_mid_outs txdis=%b link=%b locked=%b exp=11/00/00", sfp_tx_disable, link_up, fault_locked); end
        n_checks++; if (led !== 2'b00 || port_state !== 6'd0) begin n_fail++; $display("FAIL rst_mid_state led=%b state=%h exp=00/0", led, port_state); end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        tick(10);
        n_checks++; if (port_state[2:0] !== 3'd3) begin n_fail++; $display("FAIL b2b_linkup state=%0d exp=3", port_state[2:0]); end
        for (int k = 0; k < 3; k++) begin
            pcs_block_lock[0] = 1'b0;
            tick(1);
            n_checks++; if (port_state[2:0] !== 3'd2 || link_up[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_drop%0d state=%0d link=%b exp=2/0", k, port_state[2:0], link_up[0]); end
            pcs_block_lock[0] = 1'b1;
            tick(1);
            n_checks++; if (port_state[2:0] !== 3'd3) begin n_fail++; $display("FAIL b2b_up%0d state=%0d exp=3", k, port_state[2:0]); end
        end
`ifdef SFP_LINK_DOWN_CNT_EN
        n_checks++; if (link_down_cnt !== {16'd0, 16'd3}) begin n_fail++; $display("FAIL ldc_count got=%h exp=00000003", link_down_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_enable_link();
        test_los_glitch();
        test_los_pulse();
        test_fault_lockout();
        test_fault_clear();
        test_enable_drop();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
